// File: rtl/ddr3_arb_pkg.sv
// Shared widths, FSM state encoding and Avalon command payload for the DDR3 Avalon arbiter.
package ddr3_arb_pkg;

   localparam int unsigned AVL_ADDR_W = 24;
   localparam int unsigned AVL_DATA_W = 64;
   localparam int unsigned AVL_BE_W   = 8;
   localparam int unsigned AVL_SIZE_W = 7;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_ISSUE = 1'b1;

   typedef enum logic [0:0] {
      IDLE  = ST_IDLE,
      ISSUE = ST_ISSUE
   } arb_state_e;

   typedef struct packed {
      logic                  read;
      logic                  write;
      logic                  burstbegin;
      logic [AVL_ADDR_W-1:0] addr;
      logic [AVL_DATA_W-1:0] wdata;
      logic [AVL_BE_W-1:0]   be;
      logic [AVL_SIZE_W-1:0] size;
   } avl_cmd_t;

endpackage

// File: rtl/ddr3_arb_owner_fifo.sv
// Owner FIFO: remembers which port issued each outstanding read, in issue order.
module ddr3_arb_owner_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A push while full is still accepted when a pop frees the slot in the same cycle.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                  (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
   assign dout  = mem[rd_ptr[IDX_W-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[IDX_W-1:0]] <= din;
   end

endmodule

// File: rtl/ddr3_avl_arbiter.sv
// Round-robin arbiter of NUM_PORTS requesters onto one DDR3 Avalon command port with in-order read return.
// Optional per-port grant counters are enabled with DDR3_ARB_PERF_COUNTERS_EN.
module ddr3_avl_arbiter
   import ddr3_arb_pkg::*;
#(
   parameter int unsigned NUM_PORTS     = 2,
   parameter int unsigned RD_FIFO_DEPTH = 8
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic [NUM_PORTS-1:0]                  req_valid,
   input  logic [NUM_PORTS-1:0]                  req_write,
   input  logic [NUM_PORTS-1:0][AVL_ADDR_W-1:0]  req_addr,
   input  logic [NUM_PORTS-1:0][AVL_DATA_W-1:0]  req_wdata,
   input  logic [NUM_PORTS-1:0][AVL_BE_W-1:0]    req_be,
   output logic [NUM_PORTS-1:0]                  req_ack,
   output logic [NUM_PORTS-1:0]                  rsp_valid,
   output logic [AVL_DATA_W-1:0]                 rsp_data,
   input  logic                                  avl_ready,
   output logic                                  avl_burstbegin,
   output logic                                  avl_read_req,
   output logic                                  avl_write_req,
   output logic [AVL_ADDR_W-1:0]                 avl_addr,
   output logic [AVL_DATA_W-1:0]                 avl_wdata,
   output logic [AVL_BE_W-1:0]                   avl_be,
   output logic [AVL_SIZE_W-1:0]                 avl_size,
   input  logic                                  avl_rdata_valid,
   input  logic [AVL_DATA_W-1:0]                 avl_rdata,
   output logic                                  err_orphan
`ifdef DDR3_ARB_PERF_COUNTERS_EN
  ,output logic [NUM_PORTS-1:0][31:0]            grant_count
`endif
);

   localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   arb_state_e           state;
   arb_state_e           state_d;
   avl_cmd_t             cmd;
   avl_cmd_t             cmd_d;
   logic [NUM_PORTS-1:0] ack_d;
   logic [PORT_W-1:0]    last_grant;
   logic [PORT_W-1:0]    last_grant_d;
   logic [PORT_W-1:0]    winner;
   logic [PORT_W-1:0]    idx;
   logic [PORT_W-1:0]    owner;
   logic [NUM_PORTS-1:0] eligible;
   logic                 found;
   logic                 push;
   logic                 pop;
   logic                 fifo_full;
   logic                 fifo_empty;

   assign avl_read_req   = cmd.read;
   assign avl_write_req  = cmd.write;
   assign avl_burstbegin = cmd.burstbegin;
   assign avl_addr       = cmd.addr;
   assign avl_wdata      = cmd.wdata;
   assign avl_be         = cmd.be;
   assign avl_size       = cmd.size;

   // Reads need a free owner slot; writes are always eligible.
   assign eligible = req_valid & (req_write | {NUM_PORTS{!fifo_full}});

   // Round-robin search starting just above the previous winner.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
         idx = PORT_W'((32'(last_grant) + k) % NUM_PORTS);
         if (!found && eligible[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_comb begin
      state_d            = state;
      cmd_d              = cmd;
      cmd_d.burstbegin   = 1'b0;
      ack_d              = '0;
      last_grant_d       = last_grant;
      push               = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               cmd_d.read       = !req_write[winner];
               cmd_d.write      = req_write[winner];
               cmd_d.burstbegin = 1'b1;
               cmd_d.addr       = req_addr[winner];
               cmd_d.wdata      = req_wdata[winner];
               cmd_d.be         = req_be[winner];
               cmd_d.size       = AVL_SIZE_W'(1);
               ack_d[winner]    = 1'b1;
               last_grant_d     = winner;
               push             = !req_write[winner];
               state_d          = ISSUE;
            end
         end
         ISSUE: begin
            if (avl_ready) begin
               cmd_d.read  = 1'b0;
               cmd_d.write = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cmd        <= '0;
         req_ack    <= '0;
         last_grant <= PORT_W'(NUM_PORTS - 1);
      end else begin
         state      <= state_d;
         cmd        <= cmd_d;
         req_ack    <= ack_d;
         last_grant <= last_grant_d;
      end
   end

   ddr3_arb_owner_fifo #(
      .DEPTH (RD_FIFO_DEPTH),
      .WIDTH (PORT_W)
   ) u_owner_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .din     (winner),
      .dout    (owner),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Read data is steered to its owner in the cycle it arrives.
   assign pop      = avl_rdata_valid && !fifo_empty;
   assign rsp_data = avl_rdata;

   always_comb begin
      rsp_valid = '0;
      if (pop) rsp_valid[owner] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                          err_orphan <= 1'b0;
      else if (avl_rdata_valid && fifo_empty) err_orphan <= 1'b1;
   end

`ifdef DDR3_ARB_PERF_COUNTERS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant_count <= '0;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (req_ack[i] && (grant_count[i] != '1)) grant_count[i] <= grant_count[i] + 32'd1;
         end
      end
   end
`endif

endmodule
